// File: rtl/axis_maxpool_packer_pkg.sv
// Shared types and helpers for the maxpool output packer: word type,
// derived geometry and the tkeep prefix-sum used for compaction.
package axis_maxpool_pkg;

  localparam int PKG_WORD_WIDTH = 8;
  localparam int MAX_KEEP       = 64;

  typedef logic signed [PKG_WORD_WIDTH-1:0] word_t;

  function automatic int units_edges(input int units, input int kernel_h_max);
    return units + kernel_h_max - 1;
  endfunction

  function automatic int in_words(input int groups, input int units, input int kernel_h_max);
    return 2 * groups * units_edges(units, kernel_h_max);
  endfunction

  // Number of kept words strictly below index idx, i.e. the packed slot of word idx.
  function automatic int keep_prefix(input logic [MAX_KEEP-1:0] keep, input int idx);
    int n;
    n = 0;
    for (int j = 0; j < MAX_KEEP; j++) begin
      if (j < idx && keep[j]) n++;
    end
    return n;
  endfunction

  function automatic int keep_popcount(input logic [MAX_KEEP-1:0] keep);
    return keep_prefix(keep, MAX_KEEP);
  endfunction

endpackage

// File: rtl/axis_maxpool_packer_if.sv
// AXI-Stream bundle with word-granular tkeep, shared by the packer's
// input (wide, sparse) and output (dense) sides.
interface axis_maxpool_packer_if
  import axis_maxpool_pkg::*;
#(
  parameter int WORDS      = 8,
  parameter int WORD_WIDTH = PKG_WORD_WIDTH
);
  logic                        tvalid;
  logic                        tready;
  logic [WORDS*WORD_WIDTH-1:0] tdata;
  logic [WORDS-1:0]            tkeep;
  logic                        tlast;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/axis_maxpool_packer_compact.sv
// Combinational compactor: moves the kept words of one input beat to the
// low slots in ascending index order and reports how many there are.
module axis_keep_compact
  import axis_maxpool_pkg::*;
#(
  parameter int IN_WORDS   = 12,
  parameter int WORD_WIDTH = PKG_WORD_WIDTH,
  parameter int KW         = $clog2(IN_WORDS + 1)
) (
  input  logic [IN_WORDS*WORD_WIDTH-1:0] in_data,
  input  logic [IN_WORDS-1:0]            in_keep,
  output logic [IN_WORDS*WORD_WIDTH-1:0] out_data,
  output logic [KW-1:0]                  out_count
);

  logic [MAX_KEEP-1:0] keep_ext;

  // Slots above the kept count stay zero; the packer's buffer relies on that.
  always_comb begin
    keep_ext = '0;
    keep_ext[IN_WORDS-1:0] = in_keep;
    out_data = '0;
    for (int i = 0; i < IN_WORDS; i++) begin
      if (in_keep[i]) begin
        out_data[keep_prefix(keep_ext, i)*WORD_WIDTH +: WORD_WIDTH] = in_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
    out_count = KW'(keep_popcount(keep_ext));
  end

endmodule

// File: rtl/axis_maxpool_packer.sv
// Packs word-sparse maxpool output beats into a dense AXI-Stream of
// OUT_WORDS words per beat, preserving tlast and flushing partial beats.
module axis_maxpool_packer
  import axis_maxpool_pkg::*;
#(
  parameter int UNITS        = 4,
  parameter int GROUPS       = 1,
  parameter int KERNEL_H_MAX = 3,
  parameter int WORD_WIDTH   = PKG_WORD_WIDTH,
  parameter int OUT_WORDS    = 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axis_maxpool_packer_if.slave   s_axis,
  axis_maxpool_packer_if.master  m_axis
);

  localparam int UNITS_EDGES = units_edges(UNITS, KERNEL_H_MAX);
  localparam int IN_WORDS    = in_words(GROUPS, UNITS, KERNEL_H_MAX);
  localparam int BUF_WORDS   = 2 * IN_WORDS;
  localparam int IN_BITS     = IN_WORDS * WORD_WIDTH;
  localparam int BUF_BITS    = BUF_WORDS * WORD_WIDTH;
  localparam int OUT_BITS    = OUT_WORDS * WORD_WIDTH;
  localparam int CW          = $clog2(BUF_WORDS + 1);
  localparam int KW          = $clog2(IN_WORDS + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [BUF_BITS-1:0]  buf_q, buf_next, shifted, append;
  logic [CW-1:0]        count_q, count_next, pop_n, remain;
  logic [0:0]           state_q, state_next;
  logic                 ready_en_q;
  logic                 flush_pending, push, load, full_avail, last_beat;
  logic [IN_BITS-1:0]   comp_data;
  logic [KW-1:0]        comp_k;
  logic [OUT_WORDS-1:0] keep_next;
  logic                 m_valid_q, m_last_q;
  logic [OUT_BITS-1:0]  m_data_q;
  logic [OUT_WORDS-1:0] m_keep_q;

  axis_keep_compact #(
    .IN_WORDS   (IN_WORDS),
    .WORD_WIDTH (WORD_WIDTH),
    .KW         (KW)
  ) u_compact (
    .in_data   (s_axis.tdata),
    .in_keep   (s_axis.tkeep),
    .out_data  (comp_data),
    .out_count (comp_k)
  );

  // Ready comes only from registered state, so downstream tready never reaches it.
  assign flush_pending = (state_q == ST_FLUSH);
  assign s_axis.tready = ready_en_q && !flush_pending && (count_q <= CW'(BUF_WORDS - IN_WORDS));
  assign push          = s_axis.tvalid && s_axis.tready;

  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tkeep  = m_keep_q;
  assign m_axis.tlast  = m_last_q;

  // Shifting buffer: pop from index 0, append compacted words right after the survivors.
  always_comb begin
    full_avail = (count_q >= CW'(OUT_WORDS));
    load       = (!m_valid_q || m_axis.tready) && (full_avail || flush_pending);
    last_beat  = flush_pending && (count_q <= CW'(OUT_WORDS));
    pop_n      = '0;
    if (load) pop_n = full_avail ? CW'(OUT_WORDS) : count_q;
    remain     = count_q - pop_n;
    shifted    = buf_q >> (32'(pop_n) * WORD_WIDTH);
    append     = '0;
    if (push) append = {{(BUF_BITS-IN_BITS){1'b0}}, comp_data} << (32'(remain) * WORD_WIDTH);
    buf_next   = shifted | append;
    count_next = remain + (push ? CW'(comp_k) : CW'(0));
    keep_next  = '0;
    for (int j = 0; j < OUT_WORDS; j++) begin
      keep_next[j] = full_avail || (CW'(j) < count_q);
    end
    state_next = state_q;
    if (load && last_beat) state_next = ST_IDLE;
    if (push && s_axis.tlast) state_next = ST_FLUSH;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      buf_q      <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      ready_en_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
    end else begin
      buf_q      <= buf_next;
      count_q    <= count_next;
      state_q    <= state_next;
      ready_en_q <= 1'b1;
      if (load) begin
        m_valid_q <= 1'b1;
        m_data_q  <= buf_q[OUT_BITS-1:0];
        m_keep_q  <= keep_next;
        m_last_q  <= last_beat;
      end else if (m_axis.tready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_maxpool_packer.sv
// Directed scoreboard bench for axis_maxpool_packer: stimulus pushes
// hand-computed output beats, a negedge monitor pops and compares them.
module tb_axis_maxpool_packer;
  import axis_maxpool_pkg::*;

  localparam int IN_WORDS  = 12;
  localparam int OUT_WORDS = 8;
  localparam int WW        = 8;
  localparam int IN_BITS   = IN_WORDS * WW;

  typedef struct packed {
    logic [OUT_WORDS*WW-1:0] data;
    logic [OUT_WORDS-1:0]    keep;
    logic                    last;
  } beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axis_maxpool_packer_if #(.WORDS(IN_WORDS),  .WORD_WIDTH(WW)) s_if ();
  axis_maxpool_packer_if #(.WORDS(OUT_WORDS), .WORD_WIDTH(WW)) m_if ();

  axis_maxpool_packer dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axis  (s_if),
    .m_axis  (m_if)
  );

  beat_t exp_q[$];
  int    n_compared = 0;
  int    n_failed   = 0;

  function automatic beat_t seq_beat(input int first, input int n, input logic last);
    beat_t b;
    b = '0;
    for (int i = 0; i < n; i++) begin
      b.data[i*WW +: WW] = WW'(first + i);
      b.keep[i] = 1'b1;
    end
    b.last = last;
    return b;
  endfunction

  function automatic logic [IN_BITS-1:0] seq_in(input int first);
    logic [IN_BITS-1:0] d;
    for (int i = 0; i < IN_WORDS; i++) d[i*WW +: WW] = WW'(first + i);
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] req);
    n_compared++;
    if (act !== req) begin
      n_failed++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [IN_BITS-1:0] data, input logic [IN_WORDS-1:0] keep,
                               input logic last, input string name);
    int   waited;
    logic hs;
    waited = 0;
    hs = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = data;
    s_if.tkeep  = keep;
    s_if.tlast  = last;
    while (!hs && waited < 200) begin
      @(negedge aclk);
      hs = s_if.tready;
      @(posedge aclk);
      #1;
      waited++;
    end
    if (!hs) begin
      n_compared++;
      n_failed++;
      $display("[TB] FAIL %s_accept: got no handshake in 200 cycles, required handshake", name);
    end
    s_if.tvalid = 1'b0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(posedge aclk);
      c++;
    end
    repeat (3) @(posedge aclk);
    #1;
    checkOutput({name, "_drained"}, 80'(exp_q.size()), 80'd0);
  endtask

  beat_t exp_b, held_b, cur_b;
  logic  held_v = 1'b0;

  // Monitor: compare every transferred beat, and hold stability while stalled.
  always @(negedge aclk) begin
    cur_b = {m_if.tdata, m_if.tkeep, m_if.tlast};
    if (m_if.tvalid && m_if.tready) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_failed++;
        $display("[TB] FAIL unexpected_beat: got %h, required no beat", cur_b);
      end else begin
        exp_b = exp_q.pop_front();
        checkOutput("beat_data", 80'(m_if.tdata), 80'(exp_b.data));
        checkOutput("beat_keep", 80'(m_if.tkeep), 80'(exp_b.keep));
        checkOutput("beat_last", 80'(m_if.tlast), 80'(exp_b.last));
      end
    end
    if (held_v && m_if.tvalid) checkOutput("stall_hold", 80'(cur_b), 80'(held_b));
    held_v = m_if.tvalid && !m_if.tready;
    held_b = cur_b;
  end

  initial begin
    #100000;
    n_failed++;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [IN_BITS-1:0] d;
    beat_t              b;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;

    // Reset state and ready rising on the first edge after release
    #2;
    checkOutput("reset_m_tvalid", 80'(m_if.tvalid), 80'd0);
    checkOutput("reset_m_tkeep",  80'(m_if.tkeep),  80'd0);
    checkOutput("reset_m_tlast",  80'(m_if.tlast),  80'd0);
    checkOutput("reset_m_tdata",  80'(m_if.tdata),  80'd0);
    checkOutput("reset_s_tready", 80'(s_if.tready), 80'd0);
    #20 aresetn = 1'b1;
    #1 checkOutput("release_s_tready_low", 80'(s_if.tready), 80'd0);
    @(posedge aclk); #1;
    checkOutput("release_s_tready_high", 80'(s_if.tready), 80'd1);

    // Test 1: two full beats, three dense beats out
    exp_q.push_back(seq_beat(1, 8, 1'b0));
    exp_q.push_back(seq_beat(9, 8, 1'b0));
    exp_q.push_back(seq_beat(17, 8, 1'b0));
    applyStimulus(seq_in(1), 12'hFFF, 1'b0, "t1_b0");
    applyStimulus(seq_in(13), 12'hFFF, 1'b0, "t1_b1");
    waitDrain("t1");

    // Test 2: even indices kept, flushed partial beat
    b = '0;
    b.data = {8'd0, 8'd0, 8'd10, 8'd8, 8'd6, 8'd4, 8'd2, 8'd0};
    b.keep = 8'h3F;
    b.last = 1'b1;
    exp_q.push_back(b);
    applyStimulus(seq_in(0), 12'h555, 1'b1, "t2");
    waitDrain("t2");

    // Test 3: 12 + 1 words, second beat's only kept word sits at index 5
    exp_q.push_back(seq_beat(1, 8, 1'b0));
    exp_q.push_back(seq_beat(9, 5, 1'b1));
    applyStimulus(seq_in(1), 12'hFFF, 1'b0, "t3_b0");
    d = {IN_WORDS{8'h7F}};
    d[5*WW +: WW] = 8'd13;
    applyStimulus(d, 12'h020, 1'b1, "t3_b1");
    waitDrain("t3");

    // Test 4: downstream stalled for 10 cycles under continuous input
    exp_q.push_back(seq_beat(31, 8, 1'b0));
    exp_q.push_back(seq_beat(39, 8, 1'b0));
    exp_q.push_back(seq_beat(47, 8, 1'b0));
    exp_q.push_back(seq_beat(55, 8, 1'b0));
    exp_q.push_back(seq_beat(63, 4, 1'b1));
    m_if.tready = 1'b0;
    fork
      begin
        applyStimulus(seq_in(31), 12'hFFF, 1'b0, "t4_b0");
        applyStimulus(seq_in(43), 12'hFFF, 1'b0, "t4_b1");
        applyStimulus(seq_in(55), 12'hFFF, 1'b1, "t4_b2");
      end
      begin
        repeat (4) @(posedge aclk);
        #2;
        checkOutput("t4_stall_s_tready", 80'(s_if.tready), 80'd0);
        checkOutput("t4_stall_m_tvalid", 80'(m_if.tvalid), 80'd1);
        repeat (6) @(posedge aclk);
        #1 m_if.tready = 1'b1;
      end
    join
    waitDrain("t4");

    // Test 5: empty tlast beat on an empty buffer
    b = '0;
    b.last = 1'b1;
    exp_q.push_back(b);
    applyStimulus('0, 12'h000, 1'b1, "t5");
    checkOutput("t5_s_tready_low", 80'(s_if.tready), 80'd0);
    @(posedge aclk); #1;
    checkOutput("t5_s_tready_back", 80'(s_if.tready), 80'd1);
    waitDrain("t5");

    // Test 6: async reset with a stalled beat and 5 words buffered
    m_if.tready = 1'b0;
    applyStimulus(seq_in(101), 12'hFFF, 1'b0, "t6_b0");
    d = '0;
    d[0 +: WW] = 8'd113;
    applyStimulus(d, 12'h001, 1'b0, "t6_b1");
    checkOutput("t6_pre_reset_m_tvalid", 80'(m_if.tvalid), 80'd1);
    #3 aresetn = 1'b0;
    #1;
    checkOutput("t6_reset_m_tvalid", 80'(m_if.tvalid), 80'd0);
    checkOutput("t6_reset_m_tkeep",  80'(m_if.tkeep),  80'd0);
    checkOutput("t6_reset_m_tlast",  80'(m_if.tlast),  80'd0);
    checkOutput("t6_reset_s_tready", 80'(s_if.tready), 80'd0);
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;
    m_if.tready = 1'b1;
    @(posedge aclk); #1;
    checkOutput("t6_release_s_tready", 80'(s_if.tready), 80'd1);
    exp_q.push_back(seq_beat(71, 8, 1'b0));
    exp_q.push_back(seq_beat(79, 1, 1'b1));
    applyStimulus(seq_in(71), 12'h1FF, 1'b1, "t6_new");
    waitDrain("t6");

    checkOutput("final_queue_empty", 80'(exp_q.size()), 80'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
